// File: rtl/vtg_pkg.sv
// vtg_pkg: shared 640x480@60 timing defaults, the de/hs/vs control bundle and colour-bar constants.
// Contents: *_DEF timing localparams, vtg_ctrl_t, BAR_RGB table, clamp_lat() helper.
package vtg_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam bit HS_POL_DEF   = 1'b0;
    localparam bit VS_POL_DEF   = 1'b0;
    // hs/vs are carried active-high internally; polarity is applied only at the output register
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vtg_ctrl_t;
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    function automatic int clamp_lat(input int l);
        return l > 3 ? 3 : (l < 1 ? 1 : l);
    endfunction
endpackage

// File: rtl/vtg_delay_line.sv
// vtg_delay_line: DEPTH-stage (1..3) shift register for the de/hs/vs control bundle.
// Ports: clk, rstn (async active-low, clears every stage), d [W-1:0] in, q [W-1:0] out (DEPTH cycles later).
module vtg_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/video_timing_req.sv
// video_timing_req: raster timing generator that requests one pixel per active cycle and
// emits an aligned de/hs/vs/RGB stream after the response latency.
// Ports: clk, rstn (async active-low); req_en/req_sof/req_sol out; resp_red/green/blue [7:0] in;
//        vid_de/vid_hs/vid_vs out; vid_red/green/blue [7:0] out.
// Option: define VTG_COLORBAR_EN to replace response data with eight vertical colour bars.
module video_timing_req
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter bit HS_POL       = HS_POL_DEF,
    parameter bit VS_POL       = VS_POL_DEF,
    parameter int RESP_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       req_en,
    output logic       req_sof,
    output logic       req_sol,
    input  logic [7:0] resp_red,
    input  logic [7:0] resp_green,
    input  logic [7:0] resp_blue,
    output logic       vid_de,
    output logic       vid_hs,
    output logic       vid_vs,
    output logic [7:0] vid_red,
    output logic [7:0] vid_green,
    output logic [7:0] vid_blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int LAT     = clamp_lat(RESP_LATENCY);
    // inclusive last-index bounds so every constant fits the counter width
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_AL   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SL   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_AL   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SL   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_act, v_act, hs_q, vs_q;
    vtg_ctrl_t     ctrl, ctrl_d;
    logic [23:0]   rgb_nxt;

    assign h_act = h_cnt <= H_AL;
    assign v_act = v_cnt <= V_AL;

    // counters and the request-aligned control state share one register stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            req_en  <= 1'b0;
            req_sol <= 1'b0;
            req_sof <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            h_cnt   <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
            req_en  <= h_act && v_act;
            req_sol <= h_act && v_act && h_cnt == '0;
            req_sof <= h_act && v_act && h_cnt == '0 && v_cnt == '0;
            hs_q    <= h_cnt >= H_SS && h_cnt <= H_SL;
            vs_q    <= v_cnt >= V_SS && v_cnt <= V_SL;
        end
    end

    assign ctrl = '{de: req_en, hs: hs_q, vs: vs_q};

    // delay control by the response latency so delayed de marks the cycle resp_* is valid
    vtg_delay_line #(
        .DEPTH (LAT),
        .W     ($bits(vtg_ctrl_t))
    ) u_delay (
        .clk  (clk),
        .rstn (rstn),
        .d    (ctrl),
        .q    (ctrl_d)
    );

`ifdef VTG_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1;
    localparam int BW    = $clog2(BAR_W + 1);
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic          unused_resp;

    assign unused_resp = ^{resp_red, resp_green, resp_blue};

    // bar position restarts on every line; leftover pixels past the eighth bar stay black
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!ctrl_d.de) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == BW'(BAR_W - 1)) begin
            bar_px  <= '0;
            bar_idx <= bar_idx == 3'd7 ? 3'd7 : bar_idx + 1'b1;
        end else begin
            bar_px  <= bar_px + 1'b1;
        end
    end

    assign rgb_nxt = BAR_RGB[bar_idx];
`else
    assign rgb_nxt = {resp_red, resp_green, resp_blue};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vid_de                          <= 1'b0;
            vid_hs                          <= ~HS_POL;
            vid_vs                          <= ~VS_POL;
            {vid_red, vid_green, vid_blue}  <= '0;
        end else begin
            vid_de                          <= ctrl_d.de;
            vid_hs                          <= ctrl_d.hs ? HS_POL : ~HS_POL;
            vid_vs                          <= ctrl_d.vs ? VS_POL : ~VS_POL;
            {vid_red, vid_green, vid_blue}  <= ctrl_d.de ? rgb_nxt : 24'h0;
        end
    end
endmodule

// File: tb/tb_video_timing_req.sv
// tb_video_timing_req: four instances (RESP_LATENCY 1..4) on a reduced raster, checked against an
// arithmetic position model; responders echo {x, y, 0x5A} and drive junk outside valid slots.
module tb_video_timing_req;
    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int N  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_en [N], req_sof [N], req_sol [N];
    logic       vid_de [N], vid_hs [N], vid_vs [N];
    logic [7:0] resp_r [N], resp_g [N], resp_b [N];
    logic [7:0] vid_r [N], vid_g [N], vid_b [N];
    logic [24:0] hist [N][4];
    int k = 0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        video_timing_req #(
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
            .HS_POL(1'b0), .VS_POL(1'b0), .RESP_LATENCY(g + 1)
        ) dut (
            .clk(clk), .rstn(rstn),
            .req_en(req_en[g]), .req_sof(req_sof[g]), .req_sol(req_sol[g]),
            .resp_red(resp_r[g]), .resp_green(resp_g[g]), .resp_blue(resp_b[g]),
            .vid_de(vid_de[g]), .vid_hs(vid_hs[g]), .vid_vs(vid_vs[g]),
            .vid_red(vid_r[g]), .vid_green(vid_g[g]), .vid_blue(vid_b[g])
        );
    end

    // model: cycle j (1 = first edge after reset release) sits at raster position (j-1) mod FT
    function automatic int lat(input int i);
        return i + 1 > 3 ? 3 : i + 1;
    endfunction
    function automatic int ph(input int j);
        return j < 1 ? 0 : ((j - 1) % FT) % HT;
    endfunction
    function automatic int pv(input int j);
        return j < 1 ? 0 : ((j - 1) % FT) / HT;
    endfunction
    function automatic logic m_de(input int j);
        return j >= 1 && ph(j) < HA && pv(j) < VA;
    endfunction
    function automatic logic m_hs(input int j);
        return j >= 1 && ph(j) >= HA + HFP && ph(j) < HA + HFP + HSY;
    endfunction
    function automatic logic m_vs(input int j);
        return j >= 1 && pv(j) >= VA + VFP && pv(j) < VA + VFP + VSY;
    endfunction
    function automatic logic [23:0] m_rgb(input int j);
`ifdef VTG_COLORBAR_EN
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        int b;
        b = ph(j) / (HA / 8);
        return m_de(j) ? bars[b > 7 ? 7 : b] : 24'h0;
`else
        return m_de(j) ? {8'(ph(j)), 8'(pv(j)), 8'h5A} : 24'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rstn) k++;
        for (int i = 0; i < N; i++) begin
            for (int s = 3; s > 0; s--) hist[i][s] = hist[i][s-1];
            hist[i][0] = {req_en[i], 8'(ph(k)), 8'(pv(k)), 8'h5A};
            {resp_r[i], resp_g[i], resp_b[i]} = hist[i][lat(i)][24] ? hist[i][lat(i)][23:0]
                : ($urandom_range(0, 1) != 0 ? 24'hABABAB : 24'($urandom));
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < 4; s++) hist[i][s] = '0;
            {resp_r[i], resp_g[i], resp_b[i]} = 24'hABABAB;
        end
        repeat ($urandom_range(2, 4)) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) {resp_r[i], resp_g[i], resp_b[i]} = 24'hABABAB;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({req_en[i], req_sof[i], req_sol[i], vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i]}
                !== {6'b000011, 24'h0}) begin
                fails++;
                $display("FAIL reset_state dut%0d: got en/sof/sol/de/hs/vs=%b%b%b%b%b%b rgb=%h%h%h, want 000011 rgb=000000",
                         i, req_en[i], req_sof[i], req_sol[i], vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i]);
            end
        end
    endtask

    task automatic test_latency();
        int first_req [N];
        int first_de [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            first_req[i] = -1;
            first_de[i] = -1;
        end
        for (int n = 0; n < 12; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (first_req[i] < 0 && req_en[i]) first_req[i] = k;
                if (first_de[i] < 0 && vid_de[i]) first_de[i] = k;
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (first_req[i] != 1 || first_de[i] - first_req[i] != lat(i) + 1) begin
                fails++;
                $display("FAIL de_latency dut%0d: first req at %0d, de rose %0d cycles later, want req at 1 and %0d",
                         i, first_req[i], first_de[i] - first_req[i], lat(i) + 1);
            end
        end
    endtask

    task automatic test_frame_counts();
        int n_en = 0, n_sol = 0, n_sof = 0;
        int sof_k [$];
        do_reset();
        for (int n = 0; n <= FT; n++) begin
            step();
            if (k <= FT) begin
                n_en += int'(req_en[0]);
                n_sol += int'(req_en[0] && req_sol[0]);
                n_sof += int'(req_en[0] && req_sof[0]);
            end
            if (req_sof[0]) sof_k.push_back(k);
        end
        checks++;
        if (n_en != HA * VA) begin
            fails++;
            $display("FAIL frame_req_en: got %0d, want %0d", n_en, HA * VA);
        end
        checks++;
        if (n_sol != VA) begin
            fails++;
            $display("FAIL frame_req_sol: got %0d, want %0d", n_sol, VA);
        end
        checks++;
        if (n_sof != 1) begin
            fails++;
            $display("FAIL frame_req_sof: got %0d, want 1", n_sof);
        end
        checks++;
        if (sof_k.size() < 2 || sof_k[0] != 1 || sof_k[1] - sof_k[0] != FT) begin
            fails++;
            $display("FAIL frame_period: got %0d sof pulses (first at %0d), want first at 1 and period %0d",
                     sof_k.size(), sof_k.size() > 0 ? sof_k[0] : -1, FT);
        end
    endtask

    task automatic test_line_timing();
        int de_fall = -1, hs_fall = -1, vs_fall = -1;
        logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
        bit c_gap = 0, c_hw = 0, c_vgap = 0, c_vw = 0;
        do_reset();
        for (int n = 0; n < 2 * FT; n++) begin
            step();
            if (p_de && !vid_de[0]) de_fall = k;
            if (p_hs && !vid_hs[0]) begin
                hs_fall = k;
                if (!c_gap && de_fall >= 0) begin
                    c_gap = 1;
                    checks++;
                    if (k - de_fall != HFP) begin
                        fails++;
                        $display("FAIL hs_after_de: got %0d, want %0d", k - de_fall, HFP);
                    end
                end
            end
            if (!p_hs && vid_hs[0] && hs_fall >= 0 && !c_hw) begin
                c_hw = 1;
                checks++;
                if (k - hs_fall != HSY) begin
                    fails++;
                    $display("FAIL hs_width: got %0d, want %0d", k - hs_fall, HSY);
                end
            end
            if (p_vs && !vid_vs[0]) begin
                vs_fall = k;
                if (!c_vgap && de_fall >= 0) begin
                    c_vgap = 1;
                    checks++;
                    if (k - de_fall != (VFP + 1) * HT - HA) begin
                        fails++;
                        $display("FAIL vs_after_last_de: got %0d, want %0d", k - de_fall, (VFP + 1) * HT - HA);
                    end
                end
            end
            if (!p_vs && vid_vs[0] && vs_fall >= 0 && !c_vw) begin
                c_vw = 1;
                checks++;
                if (k - vs_fall != VSY * HT) begin
                    fails++;
                    $display("FAIL vs_width: got %0d, want %0d", k - vs_fall, VSY * HT);
                end
            end
            p_de = vid_de[0];
            p_hs = vid_hs[0];
            p_vs = vid_vs[0];
        end
        checks++;
        if ({c_gap, c_hw, c_vgap, c_vw} != 4'b1111) begin
            fails++;
            $display("FAIL sync_edges_seen: got %b, want 1111", {c_gap, c_hw, c_vgap, c_vw});
        end
    endtask

    task automatic test_stream(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                int j;
                logic [2:0] er;
                logic [26:0] ev;
                j = k - lat(i) - 1;
                er = {m_de(k), m_de(k) && ph(k) == 0, m_de(k) && ph(k) == 0 && pv(k) == 0};
                ev = {m_de(j), ~m_hs(j), ~m_vs(j), m_rgb(j)};
                checks++;
                if ({req_en[i], req_sol[i], req_sof[i]} !== er) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL req dut%0d k=%0d: got en/sol/sof=%b%b%b, want %b",
                                 i, k, req_en[i], req_sol[i], req_sof[i], er);
                end
                checks++;
                if ({vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i]} !== ev) begin
                    fails++;
                    if (fails < 20)
                        $display("FAIL vid dut%0d k=%0d: got de/hs/vs=%b%b%b rgb=%h%h%h, want %b%b%b rgb=%h",
                                 i, k, vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i],
                                 ev[26], ev[25], ev[24], ev[23:0]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int tv, th, n;
        tv = $urandom_range(1, VA - 1);
        th = $urandom_range(3, HA - 2);
        n = 0;
        while (!(pv(k) == tv && ph(k) == th) && n < 2 * FT) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2 * FT) begin
            fails++;
            $display("FAIL midframe_target: position (%0d,%0d) not reached within %0d cycles", th, tv, 2 * FT);
        end
        #1 rstn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({req_en[i], vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i]} !== {4'b0011, 24'h0}) begin
                fails++;
                $display("FAIL async_reset dut%0d: got en/de/hs/vs=%b%b%b%b rgb=%h%h%h, want 0011 rgb=000000",
                         i, req_en[i], vid_de[i], vid_hs[i], vid_vs[i], vid_r[i], vid_g[i], vid_b[i]);
            end
        end
        do_reset();
        step();
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({req_en[i], req_sol[i], req_sof[i], vid_de[i]} !== 4'b1110) begin
                fails++;
                $display("FAIL restart_sof dut%0d: got en/sol/sof/de=%b%b%b%b, want 1110",
                         i, req_en[i], req_sol[i], req_sof[i], vid_de[i]);
            end
        end
        test_stream(FT + 20);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame_counts();
        test_line_timing();
        do_reset();
        test_stream(2 * FT + 10);
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
